// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone widths and decoder state encoding
package wb_pkg;

  localparam int WB_ADR_W = 36;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_ACTIVE = 4'b0010,
    ST_RESP   = 4'b0100,
    ST_ERR    = 4'b1000
  } wb_state_e;

endpackage

// File: rtl/wb_timeout_ctr.sv
// rtl/wb_timeout_ctr.sv - saturating bus watchdog counter
module wb_timeout_ctr #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] C_MAX  = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != C_MAX)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Expire fires on the last allowed wait cycle, so the FSM leaves ACTIVE after exactly TIMEOUT cycles.
  assign o_expire = (r_cnt == C_LAST);

endmodule

// File: rtl/wb_decode_timeout.sv
// rtl/wb_decode_timeout.sv - Wishbone address decoder with per-cycle watchdog
module wb_decode_timeout
  import wb_pkg::*;
#(
  parameter int          NSLAVE   = 4,
  parameter int          SEL_W    = 2,
  parameter int          SEL_LSB  = 34,
  parameter int          TIMEOUT  = 1023,
  parameter logic [31:0] ERR_DATA = 32'hDEADB0B0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WB_ADR_W-1:0]        m_adr_i,
  input  logic [WB_DAT_W-1:0]        m_dat_i,
  input  logic                       m_we_i,
  input  logic [WB_SEL_W-1:0]        m_sel_i,
  input  logic                       m_stb_i,
  input  logic                       m_cyc_i,
  output logic [WB_DAT_W-1:0]        m_dat_o,
  output logic                       m_ack_o,
  output logic [WB_ADR_W-1:0]        s_adr_o,
  output logic [WB_DAT_W-1:0]        s_dat_o,
  output logic                       s_we_o,
  output logic [WB_SEL_W-1:0]        s_sel_o,
  output logic [NSLAVE-1:0]          s_stb_o,
  output logic [NSLAVE-1:0]          s_cyc_o,
  input  logic [WB_DAT_W*NSLAVE-1:0] s_dat_i,
  input  logic [NSLAVE-1:0]          s_ack_i,
  output logic                       err_o,
  output logic [WB_ADR_W-1:0]        err_adr_o,
  input  logic                       err_clr_i
);

  wb_state_e             r_state;
  logic [SEL_W-1:0]      r_idx;
  logic                  r_ack;
  logic [WB_DAT_W-1:0]   r_dat;
  logic                  r_err;
  logic [WB_ADR_W-1:0]   r_err_adr;

  logic [SEL_W-1:0]      w_idx;
  logic                  w_mapped;
  logic                  w_req;
  logic                  w_expire;
  logic                  w_sack;
  logic [WB_DAT_W-1:0]   w_sdat;
  logic [NSLAVE-1:0]     w_onehot;

  assign s_adr_o = m_adr_i;
  assign s_dat_o = m_dat_i;
  assign s_we_o  = m_we_i;
  assign s_sel_o = m_sel_i;

  assign w_idx    = m_adr_i[SEL_LSB +: SEL_W];
  assign w_mapped = (int'(w_idx) < NSLAVE);
  assign w_req    = m_cyc_i && m_stb_i;

  // Only the latched slave's ack and data are visible; stray acks from other slaves are dropped here.
  always_comb begin
    w_sack   = 1'b0;
    w_sdat   = '0;
    w_onehot = '0;
    for (int k = 0; k < NSLAVE; k++) begin
      if (r_idx == SEL_W'(k)) begin
        w_sack      = s_ack_i[k];
        w_sdat      = s_dat_i[WB_DAT_W*k +: WB_DAT_W];
        w_onehot[k] = 1'b1;
      end
    end
  end

  assign s_stb_o = (r_state == ST_ACTIVE) ? w_onehot : '0;
  assign s_cyc_o = (r_state == ST_ACTIVE) ? w_onehot : '0;

  wb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (r_state == ST_IDLE),
    .i_en     (r_state == ST_ACTIVE),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_err     <= 1'b0;
      r_err_adr <= '0;
    end else begin
      r_ack <= 1'b0;
      if (err_clr_i) begin
        r_err <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_req && w_mapped) begin
            r_state <= ST_ACTIVE;
            r_idx   <= w_idx;
          end else if (w_req) begin
            r_state   <= ST_ERR;
            r_ack     <= 1'b1;
            r_dat     <= ERR_DATA;
            r_err     <= 1'b1;
            r_err_adr <= m_adr_i;
          end
        end
        ST_ACTIVE: begin
          if (!m_cyc_i) begin
            r_state <= ST_IDLE;
          end else if (w_sack) begin
            r_state <= ST_RESP;
            r_ack   <= 1'b1;
            r_dat   <= w_sdat;
          end else if (w_expire) begin
            r_state   <= ST_ERR;
            r_ack     <= 1'b1;
            r_dat     <= ERR_DATA;
            r_err     <= 1'b1;
            r_err_adr <= m_adr_i;
          end
        end
        // RESP/ERR hold the ack for one cycle so the master has dropped its strobe before IDLE samples again.
        ST_RESP: r_state <= ST_IDLE;
        ST_ERR:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_ack_o   = r_ack;
  assign m_dat_o   = r_dat;
  assign err_o     = r_err;
  assign err_adr_o = r_err_adr;

endmodule

// File: tb/tb_wb_decode_timeout.sv
// tb/tb_wb_decode_timeout.sv - scoreboard bench for the decoder and watchdog
module tb_wb_decode_timeout;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [35:0]  m_adr = '0;
  logic [31:0]  m_dat = '0;
  logic         m_we = 1'b0;
  logic [3:0]   m_sel = '0;
  logic         stb_a = 1'b0, cyc_a = 1'b0, stb_b = 1'b0, cyc_b = 1'b0;
  logic [127:0] s_dat = {32'h5300_0003, 32'h1234_5678, 32'h5100_0001, 32'h5000_0000};
  logic [3:0]   s_ack = '0;
  logic         err_clr = 1'b0;

  logic [31:0] a_dat, a_sdat, b_dat, b_sdat;
  logic        a_ack, a_swe, a_err, b_ack, b_swe, b_err;
  logic [35:0] a_sadr, a_eadr, b_sadr, b_eadr;
  logic [3:0]  a_ssel, a_stb, a_cyc, b_ssel;
  logic [2:0]  b_stb, b_cyc;

  always #5 clk = ~clk;

  wb_decode_timeout #(.NSLAVE(4), .SEL_W(2), .SEL_LSB(34), .TIMEOUT(8), .ERR_DATA(32'hDEADB0B0)) u_dut (
    .clk(clk), .rst_n(rst_n), .m_adr_i(m_adr), .m_dat_i(m_dat), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_stb_i(stb_a), .m_cyc_i(cyc_a), .m_dat_o(a_dat), .m_ack_o(a_ack), .s_adr_o(a_sadr),
    .s_dat_o(a_sdat), .s_we_o(a_swe), .s_sel_o(a_ssel), .s_stb_o(a_stb), .s_cyc_o(a_cyc),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .err_o(a_err), .err_adr_o(a_eadr), .err_clr_i(err_clr));

  wb_decode_timeout #(.NSLAVE(3), .SEL_W(2), .SEL_LSB(34), .TIMEOUT(8), .ERR_DATA(32'hDEADB0B0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .m_adr_i(m_adr), .m_dat_i(m_dat), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_stb_i(stb_b), .m_cyc_i(cyc_b), .m_dat_o(b_dat), .m_ack_o(b_ack), .s_adr_o(b_sadr),
    .s_dat_o(b_sdat), .s_we_o(b_swe), .s_sel_o(b_ssel), .s_stb_o(b_stb), .s_cyc_o(b_cyc),
    .s_dat_i(s_dat[95:0]), .s_ack_i(s_ack[2:0]), .err_o(b_err), .err_adr_o(b_eadr), .err_clr_i(err_clr));

  typedef struct {
    int          edge_n;
    logic [31:0] dat;
    logic        err;
    logic [35:0] eadr;
    bit          is_err;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   nchecks = 0;
  int   nerrors = 0;
  int   cyc_n = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_ack) begin
      exp_t e;
      if (qa.size() == 0) begin
        check("a_unexpected_ack", 1, 0);
      end else begin
        e = qa.pop_front();
        check("a_ack_edge", cyc_n + 1, e.edge_n);
        check("a_m_dat_o", a_dat, e.dat);
        check("a_err_o", a_err, e.err);
        if (e.is_err) check("a_err_adr_o", a_eadr, e.eadr);
      end
    end
  end

  always @(negedge clk) begin
    if (b_ack) begin
      exp_t e;
      if (qb.size() == 0) begin
        check("b_unexpected_ack", 1, 0);
      end else begin
        e = qb.pop_front();
        check("b_ack_edge", cyc_n + 1, e.edge_n);
        check("b_m_dat_o", b_dat, e.dat);
        check("b_err_o", b_err, e.err);
        if (e.is_err) check("b_err_adr_o", b_eadr, e.eadr);
      end
    end
  end

  task automatic access(input bit dut, input logic [35:0] adr, input logic we, input logic [31:0] wdat,
                        input int lat, input int maxc, input bit exp_ack, input int exp_edges,
                        input logic [31:0] exp_dat, input logic exp_err, input bit is_err,
                        output int stb_cycles, output int bad);
    exp_t       e;
    int         t0;
    bit         got;
    logic [3:0] onehot, stb, cyc;
    @(posedge clk); #1;
    m_adr = adr; m_we = we; m_dat = wdat; m_sel = 4'hF;
    if (dut) begin stb_b = 1'b1; cyc_b = 1'b1; end
    else     begin stb_a = 1'b1; cyc_a = 1'b1; end
    t0 = cyc_n;
    if (exp_ack) begin
      e.edge_n = t0 + exp_edges; e.dat = exp_dat; e.err = exp_err; e.eadr = adr; e.is_err = is_err;
      if (dut) qb.push_back(e); else qa.push_back(e);
    end
    onehot = 4'b0001 << adr[35:34];
    stb_cycles = 0; bad = 0; got = 1'b0;
    for (int k = 1; k <= maxc && !got; k++) begin
      @(posedge clk); #1;
      s_ack = (k == lat) ? onehot : 4'b0000;
      @(negedge clk);
      stb = dut ? {1'b0, b_stb} : a_stb;
      cyc = dut ? {1'b0, b_cyc} : a_cyc;
      if (stb == onehot) stb_cycles++;
      else if (stb != 4'b0000) bad++;
      if (cyc != stb) bad++;
      got = dut ? b_ack : a_ack;
    end
    if (exp_ack && !got) check("ack_wait_expired", 0, 1);
    @(posedge clk); #1;
    stb_a = 1'b0; cyc_a = 1'b0; stb_b = 1'b0; cyc_b = 1'b0; s_ack = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc, bd;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_ack_o", a_ack, 0);
    check("rst_s_stb_o", a_stb, 0);
    check("rst_s_cyc_o", a_cyc, 0);
    check("rst_err_o", a_err, 0);
    check("rst_err_adr_o", a_eadr, 0);
    check("rst_m_dat_o", a_dat, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    m_adr = 36'h4_0000_0010; m_dat = 32'hCAFE_F00D; m_we = 1'b1; m_sel = 4'h5;
    #1;
    check("pass_s_adr_o", a_sadr, 36'h4_0000_0010);
    check("pass_s_dat_o", a_sdat, 32'hCAFE_F00D);
    check("pass_s_we_o", a_swe, 1);
    check("pass_s_sel_o", a_ssel, 4'h5);

    access(0, 36'h4_0000_0010, 1, 32'hCAFE_F00D, 3, 20, 1, 5, 32'h5100_0001, 0, 0, sc, bd);
    check("t1_stb_cycles", sc, 3);
    check("t1_stray_stb", bd, 0);

    access(0, 36'h8_0000_0000, 0, 32'h0, 1, 20, 1, 3, 32'h1234_5678, 0, 0, sc, bd);
    check("t2_stb_cycles", sc, 1);
    check("t2_s_we_o", a_swe, 0);

    err_clr = 1'b1;
    access(1, 36'hC_0000_0000, 0, 32'h0, 0, 20, 1, 2, 32'hDEADB0B0, 1, 1, sc, bd);
    err_clr = 1'b0;
    check("t3_no_stb", sc + bd, 0);
    check("t3_dat_hold", b_dat, 32'hDEADB0B0);

    access(0, 36'h0_0000_0100, 0, 32'h0, 0, 20, 1, 10, 32'hDEADB0B0, 1, 1, sc, bd);
    check("t4_stb_cycles", sc, 8);
    check("t4_err_sticky", a_err, 1);
    err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    check("t4_err_cleared", a_err, 0);
    check("t4_err_adr_kept", a_eadr, 36'h0_0000_0100);

    access(0, 36'h0_0000_0200, 0, 32'h0, 8, 20, 1, 10, 32'h5000_0000, 0, 0, sc, bd);
    check("t5_stb_cycles", sc, 8);
    check("t5_err_unchanged", a_err, 0);

    @(posedge clk); #1;
    m_adr = 36'h4_0000_0020; m_we = 1'b0; stb_a = 1'b1; cyc_a = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("t6_stb_before_rst", a_stb, 4'b0010);
    rst_n = 1'b0;
    #1;
    check("t6_rst_s_stb_o", a_stb, 0);
    check("t6_rst_s_cyc_o", a_cyc, 0);
    check("t6_rst_m_ack_o", a_ack, 0);
    stb_a = 1'b0; cyc_a = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);

    access(0, 36'h8_0000_0040, 0, 32'h0, 0, 2, 0, 0, 32'h0, 0, 0, sc, bd);
    check("t7_abort_stb_cycles", sc, 2);
    repeat (3) @(posedge clk);
    access(0, 36'hC_0000_0004, 1, 32'h0BAD_F00D, 2, 20, 1, 4, 32'h5300_0003, 0, 0, sc, bd);
    check("t7_slave3_stb_cycles", sc, 2);
    check("t7_slave3_stray_stb", bd, 0);

    repeat (3) @(posedge clk);
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
